// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised register between two adjacent pipeline stages.
// It carries an opaque payload, a valid bit and delay-slot flags, and counts bubbles and flushes.
// Latency: 1 cycle from inputs to outputs on an advance.
// Backpressure: none of its own. The shared stall vector selects advance, bubble or hold. flush wins over every stall pattern.
//
// Ports:
//   clk, rst          clock (rising edge); synchronous active-high reset
//   stall[STALL_W]    global stall vector, 1 = stop. This stage reads bits STAGE and STAGE+1.
//   flush             squash the stage contents (exception / mispredict)
//   clr_cnt           synchronous clear of both performance counters
//   in_valid          upstream entry is valid
//   in_payload        upstream payload
//   in_ds             upstream instruction is in a delay slot
//   in_next_ds        the next fetched instruction will be in a delay slot
//   out_valid         registered valid
//   out_payload       registered payload
//   out_ds            registered delay-slot flag
//   ds_next_o         sticky next-is-delay-slot flag, fed back to decode
//   bubble_cnt        saturating count of inserted bubbles
//   flush_cnt         saturating count of flush cycles

module pipe_stage_reg #(
  parameter int unsigned       DATA_W         = 96,
  parameter int unsigned       STALL_W        = 6,
  parameter int unsigned       STAGE          = 2,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD    = '0,
  parameter bit                SQUASH_INVALID = 1'b1,
  parameter int unsigned       CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               clr_cnt,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic               in_ds,
  input  logic               in_next_ds,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic               out_ds,
  output logic               ds_next_o,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // The downstream stall bit is stall[STAGE+1], so STAGE must leave room for it.
  generate
    if (STAGE + 2 > STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE (%0d) must be <= STALL_W-2 (%0d)", STAGE, STALL_W - 2);
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // --------------------------------------------------------------------------
  // Action decode
  // --------------------------------------------------------------------------
  logic              w_stall_up;
  logic              w_stall_dn;
  logic              w_bubble;
  logic              w_advance;
  logic [DATA_W-1:0] w_adv_payload;
  logic              w_unused_stall;

  assign w_stall_up = stall[STAGE];
  assign w_stall_dn = stall[STAGE+1];

  // Upstream stopped while downstream drains, so a bubble is inserted here.
  assign w_bubble  = ~flush & w_stall_up & ~w_stall_dn;
  // Upstream not stalled. The illegal pattern (up=0, dn=1) also lands here
  // so the stage never loses an upstream entry.
  assign w_advance = ~flush & ~w_stall_up;
  // Both stalled: no strobe, so the registers simply keep their value.

  // Invalid entries can carry NOP_PAYLOAD so that downstream logic never sees
  // stale payload bits that toggle without a valid entry behind them.
  assign w_adv_payload = (SQUASH_INVALID && !in_valid) ? NOP_PAYLOAD : in_payload;

  // Only two bits of the shared stall vector matter to this stage.
  assign w_unused_stall = ^stall;

  // --------------------------------------------------------------------------
  // Data path registers
  // --------------------------------------------------------------------------
  logic              r_valid;
  logic [DATA_W-1:0] r_payload;
  logic              r_ds;
  logic              r_ds_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_payload <= NOP_PAYLOAD;
      r_ds      <= 1'b0;
      r_ds_next <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_payload <= NOP_PAYLOAD;
      r_ds      <= 1'b0;
      r_ds_next <= 1'b0;
    end else if (w_bubble) begin
      // ds_next is deliberately untouched. The instruction that set it is
      // still upstream, and decode needs the flag when that instruction advances.
      r_valid   <= 1'b0;
      r_payload <= NOP_PAYLOAD;
      r_ds      <= 1'b0;
    end else if (w_advance) begin
      r_valid   <= in_valid;
      r_payload <= w_adv_payload;
      r_ds      <= in_ds;
      r_ds_next <= in_next_ds;
    end
  end

  assign out_valid   = r_valid;
  assign out_payload = r_payload;
  assign out_ds      = r_ds;
  assign ds_next_o   = r_ds_next;

  // --------------------------------------------------------------------------
  // Performance counters: saturating, and independent of the data path action
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_bubble_inc;
  logic             w_flush_inc;

  assign w_bubble_inc = w_bubble && (r_bubble_cnt != CNT_MAX);
  assign w_flush_inc  = flush    && (r_flush_cnt  != CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_bubble_inc) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
      if (w_flush_inc) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

  // --------------------------------------------------------------------------
  // Simulation check: the stall controller must never stall downstream while
  // upstream is free to move.
  // --------------------------------------------------------------------------
  a_legal_stall: assert property (@(posedge clk) disable iff (rst)
                                  !(!w_stall_up && w_stall_dn));

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, clr_cnt, in_valid, in_ds, in_next_ds;
  logic [95:0] in_payload;
  logic [5:0]  stall_a;
  logic [3:0]  stall_b;

  logic        a_valid, a_ds, a_dsn;
  logic [95:0] a_pay;
  logic [15:0] a_bub, a_fl;

  logic        b_valid, b_ds, b_dsn;
  logic [7:0]  b_pay;
  logic [3:0]  b_bub, b_fl;

  int checks   = 0;
  int failures = 0;

  // DUT A: default parameters
  pipe_stage_reg dut_a (
    .clk(clk), .rst(rst), .stall(stall_a), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_payload(in_payload), .in_ds(in_ds), .in_next_ds(in_next_ds),
    .out_valid(a_valid), .out_payload(a_pay), .out_ds(a_ds), .ds_next_o(a_dsn),
    .bubble_cnt(a_bub), .flush_cnt(a_fl)
  );

  // DUT B: narrow payload, different stage slot, non-zero NOP, no squash, 4-bit counters
  pipe_stage_reg #(
    .DATA_W(8), .STALL_W(4), .STAGE(1), .NOP_PAYLOAD(8'hFF),
    .SQUASH_INVALID(1'b0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .stall(stall_b), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_payload(in_payload[7:0]), .in_ds(in_ds), .in_next_ds(in_next_ds),
    .out_valid(b_valid), .out_payload(b_pay), .out_ds(b_ds), .ds_next_o(b_dsn),
    .bubble_cnt(b_bub), .flush_cnt(b_fl)
  );

  // Behavioural reference: what the stage should hold after one clock edge
  typedef struct {
    logic        v;
    logic [95:0] p;
    logic        ds;
    logic        dsn;
    int          bub;
    int          fl;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t model(mstate_t s, bit up, bit dn, bit squash,
                                    logic [95:0] pay, logic [95:0] nop, int maxc);
    mstate_t n = s;
    bit is_bubble;
    if (rst) begin
      n.v = 1'b0; n.p = nop; n.ds = 1'b0; n.dsn = 1'b0; n.bub = 0; n.fl = 0;
      return n;
    end
    is_bubble = !flush && up && !dn;
    if (flush) begin
      n.v = 1'b0; n.p = nop; n.ds = 1'b0; n.dsn = 1'b0;
    end else if (is_bubble) begin
      n.v = 1'b0; n.p = nop; n.ds = 1'b0;
    end else if (!up) begin
      n.v   = in_valid;
      n.p   = (squash && !in_valid) ? nop : pay;
      n.ds  = in_ds;
      n.dsn = in_next_ds;
    end
    if (clr_cnt) begin
      n.bub = 0; n.fl = 0;
    end else begin
      if (is_bubble && s.bub < maxc) n.bub = s.bub + 1;
      if (flush && s.fl < maxc)      n.fl  = s.fl + 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the models, then compare every output of both DUTs
  task automatic tick();
    @(posedge clk);
    ma = model(ma, stall_a[2], stall_a[3], 1'b1, in_payload, 96'h0, 65535);
    mb = model(mb, stall_b[1], stall_b[2], 1'b0, {88'h0, in_payload[7:0]}, {88'h0, 8'hFF}, 15);
    #1;
    chk("a_valid", {95'h0, a_valid}, {95'h0, ma.v});
    chk("a_payload", a_pay, ma.p);
    chk("a_ds", {95'h0, a_ds}, {95'h0, ma.ds});
    chk("a_ds_next", {95'h0, a_dsn}, {95'h0, ma.dsn});
    chk("a_bubble_cnt", {80'h0, a_bub}, 96'(ma.bub));
    chk("a_flush_cnt", {80'h0, a_fl}, 96'(ma.fl));
    chk("b_valid", {95'h0, b_valid}, {95'h0, mb.v});
    chk("b_payload", {88'h0, b_pay}, mb.p);
    chk("b_ds", {95'h0, b_ds}, {95'h0, mb.ds});
    chk("b_ds_next", {95'h0, b_dsn}, {95'h0, mb.dsn});
    chk("b_bubble_cnt", {92'h0, b_bub}, 96'(mb.bub));
    chk("b_flush_cnt", {92'h0, b_fl}, 96'(mb.fl));
  endtask

  initial begin
    ma = '{v: 1'b0, p: '0, ds: 1'b0, dsn: 1'b0, bub: 0, fl: 0};
    mb = ma;

    // Reset with a live upstream entry
    rst = 1'b1; flush = 1'b0; clr_cnt = 1'b0;
    in_valid = 1'b1; in_payload = 96'hABCD; in_ds = 1'b0; in_next_ds = 1'b0;
    stall_a = 6'b0; stall_b = 4'b0;
    tick(); tick();
    chk("rst_valid", {95'h0, a_valid}, 96'h0);
    chk("rst_payload", a_pay, 96'h0);
    chk("rst_ds_next", {95'h0, a_dsn}, 96'h0);
    chk("rst_bubble_cnt", {80'h0, a_bub}, 96'h0);
    chk("rst_flush_cnt", {80'h0, a_fl}, 96'h0);
    chk("rst_b_payload", {88'h0, b_pay}, 96'hFF);

    // Advance
    rst = 1'b0; in_payload = 96'h1234; in_ds = 1'b1; in_next_ds = 1'b1;
    tick();
    chk("adv_valid", {95'h0, a_valid}, 96'h1);
    chk("adv_payload", a_pay, 96'h1234);
    chk("adv_ds", {95'h0, a_ds}, 96'h1);
    chk("adv_ds_next", {95'h0, a_dsn}, 96'h1);

    // Invalid entry: squashed to NOP on A, passed through on B
    in_valid = 1'b0;
    tick();
    chk("squash_payload", a_pay, 96'h0);
    chk("nosquash_b_payload", {88'h0, b_pay}, 96'h34);

    // Load a valid entry with ds_next set, then bubble for three cycles
    in_valid = 1'b1; in_payload = 96'h5678;
    tick();
    stall_a = 6'b000100; in_next_ds = 1'b0;
    repeat (3) tick();
    chk("bubble_valid", {95'h0, a_valid}, 96'h0);
    chk("bubble_payload", a_pay, 96'h0);
    chk("bubble_ds_next_kept", {95'h0, a_dsn}, 96'h1);
    chk("bubble_cnt3", {80'h0, a_bub}, 96'd3);

    // Hold: everything frozen, counter does not move
    stall_a = 6'b001100; in_payload = 96'h7777;
    repeat (2) tick();
    chk("hold_payload", a_pay, 96'h0);
    chk("hold_bubble_cnt", {80'h0, a_bub}, 96'd3);

    // Flush beats a full stall while the stage holds a valid entry
    stall_a = 6'b0; in_payload = 96'h9999; in_next_ds = 1'b1;
    tick();
    chk("preflush_valid", {95'h0, a_valid}, 96'h1);
    stall_a = 6'b001100; flush = 1'b1;
    tick();
    chk("flush_valid", {95'h0, a_valid}, 96'h0);
    chk("flush_ds_next", {95'h0, a_dsn}, 96'h0);
    chk("flush_cnt1", {80'h0, a_fl}, 96'd1);
    chk("flush_bubble_unchanged", {80'h0, a_bub}, 96'd3);
    flush = 1'b0; stall_a = 6'b0;

    // Saturation on the 4-bit counters of B, then clear during a bubble
    stall_b = 4'b0010;
    repeat (20) tick();
    chk("sat_bubble_cnt", {92'h0, b_bub}, 96'd15);
    chk("param_nop_payload", {88'h0, b_pay}, 96'hFF);
    clr_cnt = 1'b1;
    tick();
    chk("clr_bubble_cnt", {92'h0, b_bub}, 96'd0);
    clr_cnt = 1'b0;
    tick();
    chk("post_clr_bubble_cnt", {92'h0, b_bub}, 96'd1);
    stall_b = 4'b0;

    // Randomized phase against the reference model, legal stall patterns only
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      clr_cnt    = ($urandom_range(0, 29) == 0);
      in_valid   = 1'($urandom);
      in_ds      = 1'($urandom);
      in_next_ds = 1'($urandom);
      in_payload = {$urandom, $urandom, $urandom};
      stall_a    = 6'($urandom);
      if (!stall_a[2]) stall_a[3] = 1'b0;
      stall_b    = 4'($urandom);
      if (!stall_b[1]) stall_b[2] = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
